// File: rtl/comparator_nbit_seq_pkg.sv
// Shared definitions for the chunked sequential comparator.
// Holds the FSM state encoding and its width so the top and any
// future observers agree on the numeric values of the states.
package comparator_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/comparator_nbit_seq_if.sv
// Request/result bundle for comparator_nbit_seq.
//   start, signed_mode, a, b : request side, driven by the master
//   busy, done, eq, gt, sm   : status/result side, driven by the slave
interface comparator_nbit_seq_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             sm;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, eq, gt, sm
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, eq, gt, sm
  );

endinterface

// File: rtl/comparator_nbit_seq_chunk.sv
// Combinational unsigned compare of one CHUNK-wide slice.
//   a, b : slice operands
//   eq   : a == b,  gt : a > b,  sm : a < b  (exactly one is high)
module comparator_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             sm
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign sm = (a < b);

endmodule

// File: rtl/comparator_nbit_seq.sv
// Sequential N-bit magnitude comparator, CHUNK bits per cycle, MSB chunk
// first with early exit on the first differing chunk.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of comparator_nbit_seq_if
//          (start/signed_mode/a/b in, busy/done/eq/gt/sm out, all registered)
// WIDTH must be an integer multiple of CHUNK.
module comparator_nbit_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  comparator_nbit_seq_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             sm_q, sm_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             c_eq, c_gt, c_sm;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order; only the top chunk carries that bit.
  always_comb begin
    a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk = b_q[idx_q*CHUNK +: CHUNK];
    if (signed_q && (idx_q == IDX_TOP)) begin
      a_chunk[CHUNK-1] = ~a_chunk[CHUNK-1];
      b_chunk[CHUNK-1] = ~b_chunk[CHUNK-1];
    end
  end

  comparator_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (a_chunk),
    .b  (b_chunk),
    .eq (c_eq),
    .gt (c_gt),
    .sm (c_sm)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    eq_d     = eq_q;
    gt_d     = gt_q;
    sm_d     = sm_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          signed_d = bus.signed_mode;
          idx_d    = IDX_TOP;
          eq_d     = 1'b0;
          gt_d     = 1'b0;
          sm_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_CMP;
        end
      end

      ST_CMP: begin
        if (!c_eq) begin
          gt_d    = c_gt;
          sm_d    = c_sm;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      sm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      sm_q     <= sm_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.sm   = sm_q;

endmodule

// File: doc/comparator_nbit_seq.md
COMPARATOR_NBIT_SEQ -- requirements
Module: comparator_nbit_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, with NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: sole clock, rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port start, input, 1 bit: request to compare; accepted only in IDLE.
REQ-007 Port signed_mode, input, 1 bit: 1 selects two's-complement comparison, 0 selects unsigned; sampled with start.
REQ-008 Port a, input, WIDTH bits: operand A; sampled with start.
REQ-009 Port b, input, WIDTH bits: operand B; sampled with start.
REQ-010 Port busy, output, 1 bit: high while the comparison is in progress (state CMP).
REQ-011 Port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-012 Port eq, output, 1 bit: a == b.
REQ-013 Port gt, output, 1 bit: a > b.
REQ-014 Port sm, output, 1 bit: a < b.

Function
REQ-015 The FSM SHALL have the states IDLE, CMP and DONE; all outputs are registered.
REQ-016 In IDLE, start=1 at a rising edge SHALL latch a, b and signed_mode, set the chunk index to NCHUNK-1, clear eq/gt/sm to 000, and enter CMP.
REQ-017 In CMP, each edge SHALL compare the latched chunk [idx*CHUNK +: CHUNK] of both operands, MSB chunk first.
REQ-018 In signed mode, the MSB chunk comparison SHALL invert bit WIDTH-1 of both operands before the unsigned compare; all other chunks compare unsigned.
REQ-019 If the chunks differ, the block SHALL set gt or sm (exactly one), set done=1, and enter DONE; no further chunks are examined (early exit).
REQ-020 If the chunks are equal and idx==0, the block SHALL set eq=1, set done=1, and enter DONE.
REQ-021 If the chunks are equal and idx>0, the block SHALL decrement idx and remain in CMP.
REQ-022 Latency SHALL be k edges from the accepting edge to done high, where k = the number of chunks examined (1..NCHUNK).
REQ-023 DONE SHALL last exactly one cycle, with done=1; the next edge SHALL return to IDLE and clear done.
REQ-024 eq/gt/sm SHALL be one-hot from DONE onward and SHALL hold until the next accepted start or reset.
REQ-025 start in CMP or DONE SHALL be ignored; changes on a/b/signed_mode after acceptance SHALL NOT affect the result.
REQ-026 With start held high continuously, a new comparison SHALL be accepted on the edge after DONE (throughput of one result per k+2 cycles).
REQ-027 WIDTH==CHUNK SHALL be legal: single-cycle CMP, with done on the first edge after acceptance.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE and set busy, done, eq, gt, sm and idx to 0, and the operand registers to 0, in any state.
REQ-029 Reset during CMP SHALL abandon the comparison with no done pulse; start is ignored on any edge where rst=1.

Structure
REQ-030 State encodings (IDLE=0, CMP=1, DONE=2) and the state-width constant SHALL live in the shared package comparator_pkg.
REQ-031 The per-chunk unsigned compare SHALL be the combinational sub-module comparator_chunk (parameter CHUNK; outputs eq, gt, sm), instantiated once.

Verification
REQ-032 WIDTH=16, CHUNK=4, unsigned: a=0xF000, b=0x0FFF -> done 1 edge after acceptance, gt=1, eq=0, sm=0.
REQ-033 Unsigned: a=0x1234, b=0x1235 -> done after 4 edges, sm=1; a=b=0xABCD -> done after 4 edges, eq=1.
REQ-034 Signed: a=0x8000 (-32768), b=0x7FFF -> sm=1 after 1 edge; the same operands unsigned -> gt=1.
REQ-035 rst asserted 2 edges after accepting a=b=0x5555 -> no done pulse, all outputs 0, IDLE; a new start is accepted on the following edge.
REQ-036 start held high, with a/b changed every cycle -> results match the operands at each accepting edge; busy/done timing per REQ-022/026; start ignored during CMP/DONE.
